mdu: RTL
========

# mdu

Multiply/divide unit for the MIPS datapath. It sits directly downstream of the register-file read and ALU operand stage inside `mips`, and owns the HI/LO architectural registers. It executes `mult`, `multu`, `div`, `divu`, `mthi` and `mtlo` as a multi-cycle operation, and asserts `busy` so the controller stalls later MDU-dependent instructions. Committed HI/LO are read out for `mfhi`/`mflo`.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for `mult`/`multu`; must be ≥ 1.
- `DIV_CYCLES`, default 10: busy cycles for `div`/`divu`; must be ≥ 1.

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset; one clock, reset is synchronous and active-high.
- `start` input 1: qualifies `op`; sampled on the rising edge.
- `op` input 3: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- `a` input 32: rs operand / dividend / mthi-mtlo source.
- `b` input 32: rt operand / divisor.
- `busy` output 1: high while a mult/div is in flight.
- `hi` output 32: committed HI register.
- `lo` output 32: committed LO register.

## Operation
- State: `IDLE`, `RUN`; down-counter `cnt`; latched result registers `res_hi` and `res_lo`; latched flag `div0`.
- `IDLE` with `start=1` and `op` in 1..4:
  - The result is computed from `a`/`b` at that edge and latched into `res_hi`/`res_lo`.
  - `cnt` loads MULT_CYCLES or DIV_CYCLES.
  - State goes to `RUN`.
- `RUN`:
  - `cnt` decrements each cycle.
  - On the edge where `cnt==1`, HI←`res_hi` and LO←`res_lo` (unless `div0`), and the block returns to `IDLE`.
- `mthi`/`mtlo` in `IDLE`: HI (resp. LO) ← `a` at that edge; no busy cycle.
- Any `start` while in `RUN` is ignored entirely: no new op, no mthi/mtlo write, operands are not re-latched. The controller is responsible for stalling.
- `start` with op 0 or 7 is ignored.
- Arithmetic:
  - `mult` uses a 64-bit signed product and `multu` a 64-bit unsigned product; HI = [63:32], LO = [31:0].
  - `div`/`divu`: LO = quotient, HI = remainder.
  - Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
  - `div` of 0x80000000 by 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Divide by zero (`b==0`, `div` or `divu`):
  - Still occupies DIV_CYCLES of busy.
  - HI and LO are left unchanged at commit.
- `hi`/`lo` always present the committed registers. During `RUN` they hold the pre-operation values.

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0, state `IDLE`, `cnt`=0, `div0`=0.
- Reset during `RUN` aborts the operation: no commit, and all of the above are cleared on that edge.
- `start` sampled at edge E with a mult op:
  - `busy`=1 in the cycles after edges E .. E+MULT_CYCLES−1.
  - `busy`=0 and the new `hi`/`lo` are visible after edge E+MULT_CYCLES.
  - Div ops behave the same with DIV_CYCLES.
- Back-to-back: a new `start` at edge E+N (the commit edge) is not accepted, because the state is still `RUN`. The earliest accepted start is edge E+N+1.
- `mthi`/`mtlo` at edge E: the new value is visible after edge E; `busy` stays 0.
- `busy` is a registered output with no combinational path from `start`.

## Test plan
- Reset, then `mult` with a=0xFFFFFFFD (−3), b=5 → `busy` high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1. `hi`/`lo` stay at 0 while busy.
- `multu` a=0xFFFFFFFF, b=2 → after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- `div` a=0xFFFFFFF9 (−7), b=2 → `busy` high 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Division corner cases:
  - `div` a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
  - `divu` a=7, b=0 after `mthi` 0x1234 and `mtlo` 0x5678 → busy for 10 cycles, then HI=0x1234 and LO=0x5678 unchanged.
- `mult` 3×4 started, then `mtlo` a=0xAAAA and a second `mult` asserted during busy → both ignored; final HI=0, LO=12. A start on the commit edge is also ignored.
- `divu` 100/7 started, `reset` asserted on the 4th busy cycle → the next cycle shows `busy`=0, HI=0, LO=0, and no later commit occurs.

Source files
------------

// File: rtl/mdu.sv
// mdu: multiply/divide unit owning the HI/LO registers.
// Results are computed at issue and committed after a fixed busy window.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [15:0] MC = 16'(MULT_CYCLES);
  localparam logic [15:0] DC = 16'(DIV_CYCLES);

  state_t      state, state_n;
  logic [15:0] cnt;
  logic [31:0] res_hi, res_lo;
  logic        div0;

  logic        accept, is_div, commit;
  logic        wr_hi, wr_lo;
  logic        sgn;
  logic [63:0] prod;
  logic [31:0] mag_a, mag_b, dvs;
  logic [31:0] uq, ur, quo, rem;

  assign busy = (state == RUN);

  // Arithmetic on magnitudes so the 0x80000000 / -1 case wraps cleanly.
  always_comb begin
    sgn   = (op == 3'd1) || (op == 3'd3);
    prod  = sgn ? {{32{a[31]}}, a} * {{32{b[31]}}, b}
                : {32'd0, a} * {32'd0, b};
    mag_a = (sgn && a[31]) ? -a : a;
    mag_b = (sgn && b[31]) ? -b : b;
    dvs   = (mag_b == 32'd0) ? 32'd1 : mag_b;
    uq    = mag_a / dvs;
    ur    = mag_a % dvs;
    quo   = (sgn && (a[31] ^ b[31])) ? -uq : uq;
    rem   = (sgn && a[31]) ? -ur : ur;
  end

  // Next-state and issue/commit decode.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    is_div  = 1'b0;
    commit  = 1'b0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            3'd1, 3'd2: accept = 1'b1;
            3'd3, 3'd4: begin
              accept = 1'b1;
              is_div = 1'b1;
            end
            3'd5:    wr_hi = 1'b1;
            3'd6:    wr_lo = 1'b1;
            default: ;
          endcase
        end
        if (accept) state_n = RUN;
      end
      RUN: begin
        if (cnt == 16'd1) begin
          commit  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Counter, latched results and committed HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= 16'd0;
      div0   <= 1'b0;
      res_hi <= 32'd0;
      res_lo <= 32'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
    end else begin
      if (accept) begin
        cnt    <= is_div ? DC : MC;
        div0   <= is_div && (b == 32'd0);
        res_hi <= is_div ? rem : prod[63:32];
        res_lo <= is_div ? quo : prod[31:0];
      end else if (state == RUN) begin
        cnt <= cnt - 16'd1;
      end
      if (commit && !div0) begin
        hi <= res_hi;
        lo <= res_lo;
      end
      if (wr_hi) hi <= a;
      if (wr_lo) lo <= a;
    end
  end

endmodule
